// File: rtl/clint_irq_ctrl.sv
// Machine-level interrupt source: 64-bit mtime/mtimecmp timer and one latched external line,
// exposed as a small register window on the data bus, driving the exception unit's interrupt input.
module clint_irq_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_we,
    input  logic        bus_re,
    output logic        bus_hit,
    output logic [31:0] bus_rdata,
    input  logic        ext_irq_in,
    input  logic        irq_ack,
    input  logic        mret,
    output logic        interrupt,
    output logic [31:0] irq_cause
);
    localparam logic [5:0]  OFF_MTIME_LO = 6'h00;
    localparam logic [5:0]  OFF_MTIME_HI = 6'h04;
    localparam logic [5:0]  OFF_CMP_LO   = 6'h08;
    localparam logic [5:0]  OFF_CMP_HI   = 6'h0C;
    localparam logic [5:0]  OFF_IRQ_EN   = 6'h10;
    localparam logic [5:0]  OFF_IRQ_PEND = 6'h14;
    localparam logic [5:0]  OFF_STATUS   = 6'h18;
    localparam logic [15:0] PS_LAST      = 16'(PRESCALE - 1);
    localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;

    logic [15:0] presc_q, presc_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] hi_snap_q, hi_snap_d;
    logic [1:0]  en_q, en_d;
    logic        ext_pend_q, ext_pend_d;
    logic        sync1_q, sync2_q, sync3_q;
    logic        in_service_q, in_service_d;
    logic        interrupt_q, interrupt_d;
    logic [31:0] cause_q, cause_d;

    logic [5:0]  off;
    logic        wr, rd, tick, timer_pend, ext_rise, ext_clr;
    logic        ext_act, tim_act, gate;

    assign bus_hit    = (bus_addr[31:6] == BASE_ADDR[31:6]) & (bus_we | bus_re);
    assign off        = bus_addr[5:0];
    assign wr         = bus_hit & bus_we;
    assign rd         = bus_hit & bus_re;
    assign tick       = (presc_q == PS_LAST);
    assign timer_pend = (mtime_q >= mtimecmp_q);
    // sync3_q holds the previous synchronised level, so a rise is seen on the third edge
    assign ext_rise   = sync2_q & ~sync3_q;
    assign ext_clr    = wr & (off == OFF_IRQ_PEND) & bus_wdata[1];
    assign ext_act    = ext_pend_q & en_q[1];
    assign tim_act    = timer_pend & en_q[0];
    assign gate       = ~in_service_q & ~irq_ack;

    assign interrupt  = interrupt_q;
    assign irq_cause  = cause_q;

    always_comb begin
        bus_rdata = '0;
        if (bus_hit) begin
            case (off)
                OFF_MTIME_LO: bus_rdata = mtime_q[31:0];
                OFF_MTIME_HI: bus_rdata = hi_snap_q;
                OFF_CMP_LO:   bus_rdata = mtimecmp_q[31:0];
                OFF_CMP_HI:   bus_rdata = mtimecmp_q[63:32];
                OFF_IRQ_EN:   bus_rdata = {30'd0, en_q};
                OFF_IRQ_PEND: bus_rdata = {30'd0, ext_pend_q, timer_pend};
                OFF_STATUS:   bus_rdata = {31'd0, in_service_q};
                default:      bus_rdata = '0;
            endcase
        end
    end

    always_comb begin
        presc_d    = tick ? '0 : presc_q + 16'd1;
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        en_d       = en_q;
        hi_snap_d  = hi_snap_q;
        // A software write to either mtime half takes precedence over that cycle's increment
        if (wr && off == OFF_MTIME_LO)      mtime_d[31:0]  = bus_wdata;
        else if (wr && off == OFF_MTIME_HI) mtime_d[63:32] = bus_wdata;
        else if (tick)                      mtime_d        = mtime_q + 64'd1;
        if (wr && off == OFF_CMP_LO) mtimecmp_d[31:0]  = bus_wdata;
        if (wr && off == OFF_CMP_HI) mtimecmp_d[63:32] = bus_wdata;
        if (wr && off == OFF_IRQ_EN) en_d = bus_wdata[1:0];
        if (rd && off == OFF_MTIME_LO) hi_snap_d = mtime_q[63:32];
        ext_pend_d   = ext_rise ? 1'b1 : (ext_clr ? 1'b0 : ext_pend_q);
        in_service_d = irq_ack ? 1'b1 : (mret ? 1'b0 : in_service_q);
        interrupt_d  = (ext_act | tim_act) & gate;
        if (!gate)        cause_d = '0;
        else if (ext_act) cause_d = CAUSE_EXT;
        else if (tim_act) cause_d = CAUSE_TIMER;
        else              cause_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            mtime_q      <= '0;
            mtimecmp_q   <= '1;
            hi_snap_q    <= '0;
            en_q         <= '0;
            ext_pend_q   <= 1'b0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync3_q      <= 1'b0;
            in_service_q <= 1'b0;
            interrupt_q  <= 1'b0;
            cause_q      <= '0;
        end else begin
            presc_q      <= presc_d;
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            hi_snap_q    <= hi_snap_d;
            en_q         <= en_d;
            ext_pend_q   <= ext_pend_d;
            sync1_q      <= ext_irq_in;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
            in_service_q <= in_service_d;
            interrupt_q  <= interrupt_d;
            cause_q      <= cause_d;
        end
    end
endmodule
